// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Bridges the multicycle control FSM to the unified instruction/data memory.
//   FSM strobes (MemRead/MemWrite/IorD/IRWrite) become a req/ready transaction;
//   the FSM is held via stall until the access completes, times out, or is
//   rejected. The unit also owns the IR and MDR and decodes the IR fields.
//
// Ports
//   clk, reset          clock, synchronous active-low reset
//   MemRead, MemWrite   FSM access strobes
//   IorD                address select (0 = pc, 1 = alu_out)
//   IRWrite             load IR from the read data of this access
//   pc, alu_out         candidate addresses
//   wr_data             store data
//   mem_rdata/mem_ready memory response
//   mem_req/mem_we/mem_addr/mem_wdata   memory request
//   stall               freeze the FSM
//   ir, mdr             instruction / memory data registers
//   opcode..funct7      IR field slices
//   err_code            sticky error: 00 none, 01 timeout, 10 misaligned,
//                       11 read+write conflict
module mem_access_unit #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              IorD,
  input  logic              IRWrite,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              stall,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] mdr,
  output logic [6:0]        opcode,
  output logic [4:0]        rd,
  output logic [2:0]        funct3,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  output logic [6:0]        funct7,
  output logic [1:0]        err_code
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
  localparam logic [1:0] ERR_MISALIGN = 2'b10;
  localparam logic [1:0] ERR_CONFLICT = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [CNT_W-1:0]  wait_cnt;
  logic              irw_flag;

  logic              start;
  logic [ADDR_W-1:0] sel_addr;
  logic              misaligned;
  logic              conflict;
  logic              timeout_hit;

  always_comb begin
    start       = (MemRead | MemWrite) && (state == IDLE);
    sel_addr    = IorD ? alu_out : pc;
    misaligned  = (sel_addr[1:0] != 2'b00);
    conflict    = MemRead & MemWrite;
    timeout_hit = (wait_cnt == CNT_LAST);
    // Combinational so the FSM freezes in the very cycle it issues a strobe.
    stall       = reset & (start | (state == BUSY));
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (misaligned || conflict) state_nx = DONE;
          else                        state_nx = BUSY;
        end
      end
      BUSY: begin
        if (mem_ready || timeout_hit) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ir        <= '0;
      mdr       <= '0;
      err_code  <= ERR_NONE;
      wait_cnt  <= '0;
      irw_flag  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start) begin
            // Misalignment is checked ahead of the conflict; first error sticks.
            if (misaligned) begin
              if (err_code == ERR_NONE) err_code <= ERR_MISALIGN;
            end else if (conflict) begin
              if (err_code == ERR_NONE) err_code <= ERR_CONFLICT;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= MemWrite;
              mem_addr  <= sel_addr;
              mem_wdata <= wr_data;
              irw_flag  <= IRWrite;
              wait_cnt  <= '0;
            end
          end
        end
        BUSY: begin
          // Ready takes priority over a coincident timeout.
          if (mem_ready) begin
            mem_req <= 1'b0;
            if (!mem_we) begin
              mdr <= mem_rdata;
              if (irw_flag) ir <= mem_rdata;
            end
          end else if (timeout_hit) begin
            mem_req <= 1'b0;
            if (err_code == ERR_NONE) err_code <= ERR_TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    opcode = ir[6:0];
    rd     = ir[11:7];
    funct3 = ir[14:12];
    rs1    = ir[19:15];
    rs2    = ir[24:20];
    funct7 = ir[31:25];
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits directly downstream of the multicycle control FSM and between the datapath and the unified instruction/data memory.
- Turns the FSM's MemRead/MemWrite/IorD/IRWrite strobes into a req/ready memory transaction and holds the FSM with a stall while memory responds.
- Latches the instruction register (IR) and memory data register (MDR), and decodes IR fields, including the opcode the FSM consumes.

Parameters:
- ADDR_W, 32, memory address width.
- DATA_W, 32, data and instruction width.
- TIMEOUT, 16, maximum cycles spent in BUSY waiting for mem_ready before aborting; minimum 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset.
- MemRead  input  1  FSM read strobe.
- MemWrite  input  1  FSM write strobe.
- IorD  input  1  address select: 0 = pc, 1 = alu_out.
- IRWrite  input  1  load IR from read data.
- pc  input  ADDR_W  program counter.
- alu_out  input  ADDR_W  ALUOut register value (data address).
- wr_data  input  DATA_W  B register value (store data).
- mem_rdata  input  DATA_W  memory read data; valid when mem_ready=1.
- mem_ready  input  1  memory completes the current request.
- mem_req  output  1  memory request.
- mem_we  output  1  write enable, qualified by mem_req.
- mem_addr  output  ADDR_W  request address.
- mem_wdata  output  DATA_W  store data.
- stall  output  1  holds the FSM in its current state.
- ir  output  DATA_W  instruction register.
- mdr  output  DATA_W  memory data register.
- opcode  output  7  ir[6:0].
- rd  output  5  ir[11:7].
- funct3  output  3  ir[14:12].
- rs1  output  5  ir[19:15].
- rs2  output  5  ir[24:20].
- funct7  output  7  ir[31:25].
- err_code  output  2  sticky error code: 00 none, 01 timeout, 10 misaligned, 11 read+write conflict.

Behaviour:
- Reset (reset=0 at a clock edge):
  - State goes to IDLE.
  - mem_req, mem_we, mem_addr, mem_wdata, ir, mdr and err_code all clear to 0.
  - stall=0 while reset is low.
  - Reset aborts an in-flight access immediately; mem_req drops in the cycle after the edge.
- States are IDLE, BUSY and DONE.
- start = (MemRead|MemWrite) in IDLE.
  - stall = start | (state==BUSY). Combinational, so the FSM freezes in the same cycle it requests.
  - stall=0 in DONE.
- IDLE with start:
  - Latch mem_addr = IorD ? alu_out : pc.
  - Latch mem_wdata = wr_data, mem_we = MemWrite, and the IRWrite flag.
  - Clear the wait counter.
  - Next state is BUSY with mem_req=1.
- IDLE, error cases (checked before issuing; both go to DONE with no request issued):
  - Selected address [1:0] != 00: no request; err_code=10 if currently 00; next state DONE.
  - MemRead and MemWrite both high: no request; err_code=11 if currently 00; next state DONE.
- BUSY:
  - mem_req=1 with mem_addr, mem_we and mem_wdata held stable.
  - Counter increments each cycle.
- BUSY with mem_ready=1:
  - A read loads mdr = mem_rdata.
  - If the latched IRWrite flag is set, ir = mem_rdata in the same edge.
  - A write changes neither register.
  - mem_req drops; next state DONE.
- BUSY with counter == TIMEOUT-1 and mem_ready=0:
  - Abort with mem_req dropped; ir and mdr unchanged.
  - err_code=01 if currently 00; next state DONE.
- mem_ready and timeout in the same cycle: ready wins, no error.
- DONE:
  - Exactly one cycle with stall=0, so the FSM advances.
  - MemRead/MemWrite are ignored (the FSM still shows the old state).
  - Next state is IDLE.
- Latency: request-to-release is 2 cycles of stall plus (N-1) wait cycles, where N is the number of BUSY cycles until mem_ready (N ≥ 1).
- ir is written only via IRWrite; mdr only on a completed read. Both hold otherwise.
- Field outputs are combinational slices of ir.
- err_code is sticky: first error wins, cleared only by reset.
- mem_ready outside BUSY is ignored.

Test Plan:
- Fetch: reset released, pc=0x00000010, MemRead=1, IorD=0, IRWrite=1, memory returns 0x00B50533 with mem_ready in the first BUSY cycle.
  - Expected: mem_addr=0x10, stall high 2 cycles, ir=0x00B50533, opcode=0110011, rd=10, rs1=10, rs2=11, funct3=0, funct7=0, mdr=0x00B50533, err_code=00.
- Load with 3-cycle wait: IorD=1, alu_out=0x104, IRWrite=0, ready on the third BUSY cycle, data 0xDEADBEEF.
  - Expected: mem_addr=0x104, stall high 4 cycles, mdr=0xDEADBEEF, ir unchanged.
- Store: MemWrite=1, alu_out=0x200, wr_data=0x12345678, ready after 1 cycle.
  - Expected: mem_we=1, mem_wdata=0x12345678, mdr and ir unchanged.
- Timeout: TIMEOUT=4, mem_ready never asserted.
  - Expected: mem_req high exactly 4 cycles, then DONE, err_code=01; a subsequent misaligned access leaves err_code=01.
- Misaligned and conflict:
  - alu_out=0x102 with IorD=1: mem_req never asserts, err_code=10.
  - After reset, MemRead=MemWrite=1: err_code=11.
- Reset mid-BUSY: reset=0 on the second BUSY cycle.
  - Expected: next cycle mem_req=0, stall=0, ir=mdr=0, err_code=00; after release a new fetch completes normally.
